// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM state type for the register file
package regfile_pkg;
    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;
endpackage

// File: rtl/regfile_rd_mux.sv
// regfile_rd_mux: DEPTH:1 combinational entry selector over a flattened array
module regfile_rd_mux #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic [DEPTH*WIDTH-1:0] mem_flat,
    input  logic [AW-1:0]          addr,
    output logic [WIDTH-1:0]       data
);
    assign data = mem_flat[addr*WIDTH +: WIDTH];
endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x WIDTH register file, one write port, two registered read ports
// Define REGFILE_BYPASS_EN for write-first same-address reads; default is read-first.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic             ready,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re_a,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    output logic             rvalid_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rvalid_b
);
    state_e             state_q, state_d;
    logic [AW-1:0]      ptr_q, ptr_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [DEPTH*WIDTH-1:0] mem_flat;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [WIDTH-1:0]   mem_wdata;
    logic               w_acc, rd_acc_a, rd_acc_b, fwd_a, fwd_b;
    logic [WIDTH-1:0]   mux_a, mux_b;
    logic [WIDTH-1:0]   rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic               rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;

    assign ready    = state_q == RUN;
    assign w_acc    = ready && !clr && we;
    assign rd_acc_a = ready && re_a;
    assign rd_acc_b = ready && re_b;

`ifdef REGFILE_BYPASS_EN
    assign fwd_a = w_acc && waddr == raddr_a;
    assign fwd_b = w_acc && waddr == raddr_b;
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

    // The sweep shares the single write port so the array stays RAM-shaped
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mem_we    = w_acc;
        mem_addr  = waddr;
        mem_wdata = wdata;
        if (state_q == INIT) begin
            mem_we    = 1'b1;
            mem_addr  = ptr_q;
            mem_wdata = '0;
            ptr_d     = clr ? '0 : ptr_q + 1'b1;
            state_d   = (!clr && ptr_q == AW'(DEPTH - 1)) ? RUN : INIT;
        end else if (clr) begin
            state_d = INIT;
            ptr_d   = '0;
        end
    end

    always_comb begin
        rvalid_a_d = rd_acc_a;
        rvalid_b_d = rd_acc_b;
        rdata_a_d  = !rd_acc_a ? rdata_a_q : fwd_a ? wdata : mux_a;
        rdata_b_d  = !rd_acc_b ? rdata_b_q : fwd_b ? wdata : mux_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            ptr_q      <= '0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_addr] <= mem_wdata;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
        assign mem_flat[i*WIDTH +: WIDTH] = mem_q[i];
    end

    regfile_rd_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mux_a (
        .mem_flat (mem_flat),
        .addr     (raddr_a),
        .data     (mux_a)
    );

    regfile_rd_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mux_b (
        .mem_flat (mem_flat),
        .addr     (raddr_b),
        .data     (mux_b)
    );

    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
endmodule
